mem_rd_ctrl: RTL and testbench

- Read-side companion to the memory controller's store path.
- Once operands have been written into the 128x32 single-port RAM, this block walks the operand region and reads consecutive word pairs as opa/opb.
- Each pair is handed to the FPU with a valid/ready handshake; the block waits for the FPU result and writes it back into the RAM result region.
- It signals completion and errors to the memory controller / top-level sequencer.

---
 rtl/mem_rd_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_rd_ctrl.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_rd_ctrl
// Description : Read-side sequencer for the 128x32 operand/result RAM.
//               Walks the operand region two words at a time and presents
//               each pair to the FPU as opa/opb over a valid/ready handshake.
//               It then waits for the FPU result, guarded by an 8-bit
//               watchdog, and writes the result into the result region at
//               RES_BASE + pair index. Completion and errors are reported to
//               the memory controller / top-level sequencer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   mr_clk, mr_reset_n        clock (rising edge), async active-low reset
//   mr_start                  one-cycle request, honoured only while idle
//   mr_src_base, mr_pair_cnt  first opa address / pair count, taken with start
//   mr_mem_addr/we/wdata      RAM address, write enable and write data
//   mr_mem_rdata              RAM read data, one cycle after the address
//   mr_opa, mr_opb            registered operands to the FPU
//   mr_op_valid               operands valid
//   mr_fpu_ready              FPU accepts operands
//   mr_fpu_done/result        FPU result strobe and data
//   mr_busy                   high in every state except IDLE
//   mr_done                   one-cycle pulse on completion, reject or abort
//   mr_err                    sticky error, cleared by the next start
// ============================================================================
module mem_rd_ctrl #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int RES_BASE = 64,
    parameter int TIMEOUT  = 255
) (
    input  logic              mr_clk,
    input  logic              mr_reset_n,
    input  logic              mr_start,
    input  logic [ADDR_W-1:0] mr_src_base,
    input  logic [5:0]        mr_pair_cnt,
    output logic [ADDR_W-1:0] mr_mem_addr,
    output logic              mr_mem_we,
    output logic [DATA_W-1:0] mr_mem_wdata,
    input  logic [DATA_W-1:0] mr_mem_rdata,
    output logic [DATA_W-1:0] mr_opa,
    output logic [DATA_W-1:0] mr_opb,
    output logic              mr_op_valid,
    input  logic              mr_fpu_ready,
    input  logic              mr_fpu_done,
    input  logic [DATA_W-1:0] mr_fpu_result,
    output logic              mr_busy,
    output logic              mr_done,
    output logic              mr_err
);

    // Range checks are one bit wider than the address so that the end of a
    // region (which may equal the RAM size) never wraps.
    localparam int              c_CHK_W     = ADDR_W + 1;
    localparam int              c_MEM_WORDS = 1 << ADDR_W;
    localparam logic [7:0]      c_WD_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_A     = 3'd1,
        S_RD_B     = 3'd2,
        S_CAP_B    = 3'd3,
        S_ISSUE    = 3'd4,
        S_WAIT_RES = 3'd5,
        S_WRITE    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t              r_state;
    logic [5:0]          r_idx;
    logic [5:0]          r_cnt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [7:0]          r_wd;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;
    logic                r_op_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    // ------------------------------------------------------------------
    // Request validation
    // ------------------------------------------------------------------
    logic [c_CHK_W-1:0]  w_src_end;
    logic [c_CHK_W-1:0]  w_res_end;
    logic                w_reject;
    logic                w_last_pair;
    logic [ADDR_W-1:0]   w_res_addr;

    // One past the last operand word must not run into the result region,
    // and the result region must fit inside the RAM.
    assign w_src_end   = c_CHK_W'(mr_src_base) + c_CHK_W'({mr_pair_cnt, 1'b0});
    assign w_res_end   = c_CHK_W'(RES_BASE) + c_CHK_W'(mr_pair_cnt);
    assign w_reject    = (mr_pair_cnt == 6'd0)
                       | (w_src_end > c_CHK_W'(RES_BASE))
                       | (w_res_end > c_CHK_W'(c_MEM_WORDS));

    assign w_last_pair = (r_idx == (r_cnt - 6'd1));
    assign w_res_addr  = ADDR_W'(RES_BASE) + ADDR_W'(r_idx);

    // ------------------------------------------------------------------
    // Sequencer. Every output is a register, updated on the transition
    // into the state in which it must be seen.
    // ------------------------------------------------------------------
    always_ff @(posedge mr_clk or negedge mr_reset_n) begin
        if (!mr_reset_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 6'd0;
            r_cnt       <= 6'd0;
            r_ptr       <= '0;
            r_wd        <= 8'd0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_op_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // mr_done is a pulse; only the transitions below raise it.
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (mr_start) begin
                        if (w_reject) begin
                            // Rejected requests never leave IDLE.
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_err      <= 1'b0;
                            r_ptr      <= mr_src_base;
                            r_cnt      <= mr_pair_cnt;
                            r_idx      <= 6'd0;
                            r_mem_addr <= mr_src_base;
                            r_busy     <= 1'b1;
                            r_state    <= S_RD_A;
                        end
                    end
                end

                S_RD_A: begin
                    // mem[ptr] is being read now; present ptr+1 next.
                    r_mem_addr <= r_ptr + ADDR_W'(1);
                    r_state    <= S_RD_B;
                end

                S_RD_B: begin
                    r_opa   <= mr_mem_rdata;
                    r_state <= S_CAP_B;
                end

                S_CAP_B: begin
                    r_opb      <= mr_mem_rdata;
                    r_op_valid <= 1'b1;
                    r_state    <= S_ISSUE;
                end

                S_ISSUE: begin
                    // opa/opb are untouched here, so they hold while stalled.
                    if (mr_fpu_ready) begin
                        r_op_valid <= 1'b0;
                        r_wd       <= 8'd0;
                        r_state    <= S_WAIT_RES;
                    end
                end

                S_WAIT_RES: begin
                    r_wd <= r_wd + 8'd1;
                    // A result arriving on the last watchdog cycle still wins.
                    if (mr_fpu_done) begin
                        r_mem_wdata <= mr_fpu_result;
                        r_mem_addr  <= w_res_addr;
                        r_mem_we    <= 1'b1;
                        r_state     <= S_WRITE;
                    end else if (r_wd == c_WD_LAST) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_WRITE: begin
                    r_mem_we <= 1'b0;
                    if (w_last_pair) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx      <= r_idx + 6'd1;
                        r_ptr      <= r_ptr + ADDR_W'(2);
                        r_mem_addr <= r_ptr + ADDR_W'(2);
                        r_state    <= S_RD_A;
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mr_mem_addr  = r_mem_addr;
    assign mr_mem_we    = r_mem_we;
    assign mr_mem_wdata = r_mem_wdata;
    assign mr_opa       = r_opa;
    assign mr_opb       = r_opb;
    assign mr_op_valid  = r_op_valid;
    assign mr_busy      = r_busy;
    assign mr_done      = r_done;
    assign mr_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_rd_ctrl
// Description : Self-checking bench for mem_rd_ctrl with a synchronous-read
//               RAM model and a simple FPU responder. Expected operand pairs
//               and result writes are queued when a job is launched and
//               consumed as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_rd_ctrl;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 32;
    localparam int RES_BASE = 64;
    localparam int TIMEOUT  = 255;

    logic              mr_clk = 1'b0;
    logic              mr_reset_n;
    logic              mr_start;
    logic [ADDR_W-1:0] mr_src_base;
    logic [5:0]        mr_pair_cnt;
    logic [ADDR_W-1:0] mr_mem_addr;
    logic              mr_mem_we;
    logic [DATA_W-1:0] mr_mem_wdata;
    logic [DATA_W-1:0] mr_mem_rdata;
    logic [DATA_W-1:0] mr_opa;
    logic [DATA_W-1:0] mr_opb;
    logic              mr_op_valid;
    logic              mr_fpu_ready;
    logic              mr_fpu_done;
    logic [DATA_W-1:0] mr_fpu_result;
    logic              mr_busy;
    logic              mr_done;
    logic              mr_err;

    mem_rd_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RES_BASE (RES_BASE),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .mr_clk        (mr_clk),
        .mr_reset_n    (mr_reset_n),
        .mr_start      (mr_start),
        .mr_src_base   (mr_src_base),
        .mr_pair_cnt   (mr_pair_cnt),
        .mr_mem_addr   (mr_mem_addr),
        .mr_mem_we     (mr_mem_we),
        .mr_mem_wdata  (mr_mem_wdata),
        .mr_mem_rdata  (mr_mem_rdata),
        .mr_opa        (mr_opa),
        .mr_opb        (mr_opb),
        .mr_op_valid   (mr_op_valid),
        .mr_fpu_ready  (mr_fpu_ready),
        .mr_fpu_done   (mr_fpu_done),
        .mr_fpu_result (mr_fpu_result),
        .mr_busy       (mr_busy),
        .mr_done       (mr_done),
        .mr_err        (mr_err)
    );

    always #5 mr_clk = ~mr_clk;

    // ------------------------------------------------------------------
    // RAM model: synchronous read, write on mr_mem_we, bulk init on ram_init
    // ------------------------------------------------------------------
    logic [31:0] ram [0:127];
    logic        ram_init = 1'b0;

    function automatic logic [31:0] init_val(int a);
        if (a == 0) return 32'h3F80_0000;
        if (a == 1) return 32'h4000_0000;
        if (a < 64) return 32'h1000_0000 + 32'(a) * 32'h0001_0101;
        return 32'hDEAD_0000 + 32'(a);
    endfunction

    always @(posedge mr_clk) begin
        if (ram_init) begin
            for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
        end else if (mr_mem_we) begin
            ram[mr_mem_addr] <= mr_mem_wdata;
        end
        mr_mem_rdata <= ram[mr_mem_addr];
    end

    logic [107:0] w_outs;
    assign w_outs = {mr_mem_addr, mr_mem_we, mr_mem_wdata, mr_opa, mr_opb,
                     mr_op_valid, mr_busy, mr_done, mr_err};

    // ------------------------------------------------------------------
    // Bench state
    // ------------------------------------------------------------------
    int vec  = 0;
    int miss = 0;

    logic [63:0] op_q[$];   // expected {opa, opb} per pair
    logic [38:0] wr_q[$];   // expected {addr, data} per result write
    logic [31:0] res_q[$];  // results the FPU model returns, in order

    int done_dly   = 1;     // cycles from handshake to done; 0 = never
    int done_cd    = 0;
    bit done_arm   = 1'b0;
    int stall_left = 0;     // valid cycles on which ready is held low

    logic              ev_valid, ev_hs, ev_wr, ev_done, ev_busy, ev_err;
    logic [ADDR_W-1:0] ev_addr;
    logic [31:0]       ev_wdata, ev_opa, ev_opb;

    // Advance one cycle: sample outputs at the falling edge, then drive the
    // FPU inputs that the next rising edge will see.
    task automatic step();
        @(negedge mr_clk);
        ev_valid = mr_op_valid;
        ev_wr    = mr_mem_we;
        ev_addr  = mr_mem_addr;
        ev_wdata = mr_mem_wdata;
        ev_done  = mr_done;
        ev_busy  = mr_busy;
        ev_err   = mr_err;
        ev_opa   = mr_opa;
        ev_opb   = mr_opb;
        mr_start = 1'b0;
        mr_fpu_done = 1'b0;
        if (done_arm) begin
            done_cd--;
            if (done_cd == 0) begin
                done_arm    = 1'b0;
                mr_fpu_done = 1'b1;
                if (res_q.size() != 0) mr_fpu_result = res_q.pop_front();
                else                   mr_fpu_result = 32'h0;
            end
        end
        if (mr_op_valid && stall_left > 0) begin
            mr_fpu_ready = 1'b0;
            stall_left--;
        end else begin
            mr_fpu_ready = 1'b1;
        end
        ev_hs = mr_op_valid && mr_fpu_ready;
        if (ev_hs && done_dly > 0) begin
            done_arm = 1'b1;
            done_cd  = done_dly;
        end
    endtask

    task automatic init_ram();
        ram_init = 1'b1;
        step();
        ram_init = 1'b0;
        op_q.delete();
        wr_q.delete();
        res_q.delete();
        done_arm   = 1'b0;
        stall_left = 0;
    endtask

    task automatic launch(input logic [6:0] src, input logic [5:0] cnt);
        mr_src_base = src;
        mr_pair_cnt = cnt;
        mr_start    = 1'b1;
    endtask

    task automatic queue_job(input int src, input int cnt, input logic [31:0] res0);
        for (int i = 0; i < cnt; i++) begin
            op_q.push_back({init_val(src + 2 * i), init_val(src + 2 * i + 1)});
            res_q.push_back(res0 + 32'(i));
            wr_q.push_back({7'(RES_BASE + i), res0 + 32'(i)});
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        mr_reset_n = 1'b0;
        repeat (3) @(negedge mr_clk);
        vec++;
        if (w_outs !== 108'h0) begin
            miss++;
            $display("FAIL reset_outputs: got %h required 0", w_outs);
        end
        mr_reset_n = 1'b1;
        step();
        vec++;
        if (w_outs !== 108'h0) begin
            miss++;
            $display("FAIL idle_after_reset: got %h required 0", w_outs);
        end
    endtask

    task automatic test_single();
        int busy_n = 0, hs_n = 0;
        bit fin = 1'b0;
        init_ram();
        op_q.push_back({32'h3F80_0000, 32'h4000_0000});
        res_q.push_back(32'h4040_0000);
        wr_q.push_back({7'd64, 32'h4040_0000});
        done_dly = 1;
        launch(7'd0, 6'd1);
        for (int c = 0; c < 40 && !fin; c++) begin
            step();
            busy_n += int'(ev_busy);
            if (ev_valid) begin
                vec++;
                if (op_q.size() == 0 || {ev_opa, ev_opb} !== op_q[0]) begin
                    miss++;
                    $display("FAIL single_ops: got %h_%h", ev_opa, ev_opb);
                end
                if (ev_hs) begin hs_n++; if (op_q.size() != 0) op_q.delete(0); end
            end
            if (ev_wr) begin
                vec++;
                if (wr_q.size() == 0 || {ev_addr, ev_wdata} !== wr_q[0]) begin
                    miss++;
                    $display("FAIL single_write: got addr %0d data %h", ev_addr, ev_wdata);
                end
                if (wr_q.size() != 0) wr_q.delete(0);
            end
            if (ev_done) fin = 1'b1;
        end
        vec++;
        if (!fin || ev_err !== 1'b0) begin
            miss++;
            $display("FAIL single_done: done seen %0d err %b required done with err 0", fin, ev_err);
        end
        vec++;
        if (busy_n != 7 || hs_n != 1) begin
            miss++;
            $display("FAIL single_busy: busy %0d hs %0d required 7 and 1", busy_n, hs_n);
        end
        step();
        vec++;
        if ({ev_done, ev_busy} !== 2'b00 || ram[64] !== 32'h4040_0000 || wr_q.size() != 0) begin
            miss++;
            $display("FAIL single_end: done %b busy %b mem64 %h pending %0d required 0 0 40400000 0", ev_done, ev_busy, ram[64], wr_q.size());
        end
    endtask

    task automatic test_multi();
        int hs_n = 0;
        bit fin = 1'b0;
        init_ram();
        queue_job(10, 4, 32'hA0);
        done_dly = 1;
        launch(7'd10, 6'd4);
        for (int c = 0; c < 80 && !fin; c++) begin
            step();
            if (ev_valid) begin
                vec++;
                if (op_q.size() == 0 || {ev_opa, ev_opb} !== op_q[0]) begin
                    miss++;
                    $display("FAIL multi_ops: got %h_%h", ev_opa, ev_opb);
                end
                if (ev_hs) begin hs_n++; if (op_q.size() != 0) op_q.delete(0); end
            end
            if (ev_wr) begin
                vec++;
                if (wr_q.size() == 0 || {ev_addr, ev_wdata} !== wr_q[0]) begin
                    miss++;
                    $display("FAIL multi_write: got addr %0d data %h", ev_addr, ev_wdata);
                end
                if (wr_q.size() != 0) wr_q.delete(0);
            end
            if (ev_done) fin = 1'b1;
        end
        vec++;
        if (!fin || hs_n != 4 || ev_err !== 1'b0 || wr_q.size() != 0) begin
            miss++;
            $display("FAIL multi_end: done %0d hs %0d err %b pending %0d required 1 4 0 0", fin, hs_n, ev_err, wr_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            vec++;
            if (ram[64 + i] !== 32'hA0 + 32'(i)) begin
                miss++;
                $display("FAIL multi_mem: mem[%0d] %h required %h", 64 + i, ram[64 + i], 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        int stall_n = 0;
        bit fin = 1'b0;
        init_ram();
        queue_job(2, 2, 32'h1111);
        done_dly   = 2;
        stall_left = 5;
        launch(7'd2, 6'd2);
        for (int c = 0; c < 80 && !fin; c++) begin
            step();
            if (ev_valid) begin
                vec++;
                if (op_q.size() == 0 || {ev_opa, ev_opb} !== op_q[0] || ev_wr !== 1'b0) begin
                    miss++;
                    $display("FAIL bp_hold: got %h_%h we %b", ev_opa, ev_opb, ev_wr);
                end
                if (ev_hs) begin if (op_q.size() != 0) op_q.delete(0); end
                else stall_n++;
            end
            if (ev_wr) begin
                vec++;
                if (wr_q.size() == 0 || {ev_addr, ev_wdata} !== wr_q[0]) begin
                    miss++;
                    $display("FAIL bp_write: got addr %0d data %h", ev_addr, ev_wdata);
                end
                if (wr_q.size() != 0) wr_q.delete(0);
            end
            if (ev_done) fin = 1'b1;
        end
        vec++;
        if (!fin || stall_n != 5 || wr_q.size() != 0 || ev_err !== 1'b0) begin
            miss++;
            $display("FAIL bp_end: done %0d stalls %0d pending %0d err %b required 1 5 0 0", fin, stall_n, wr_q.size(), ev_err);
        end
    endtask

    task automatic test_range_err();
        logic [6:0] srcs [3];
        logic [5:0] cnts [3];
        bit fin = 1'b0;
        srcs = '{7'd0, 7'd60, 7'd0};
        cnts = '{6'd0, 6'd3, 6'd33};
        init_ram();
        for (int t = 0; t < 3; t++) begin
            launch(srcs[t], cnts[t]);
            step();
            vec++;
            if ({ev_done, ev_err, ev_busy, ev_wr} !== 4'b1100) begin
                miss++;
                $display("FAIL range_reject%0d: done/err/busy/we %b required 1100", t, {ev_done, ev_err, ev_busy, ev_wr});
            end
            step();
            vec++;
            if ({ev_done, ev_err, ev_busy, ev_wr} !== 4'b0100) begin
                miss++;
                $display("FAIL range_after%0d: done/err/busy/we %b required 0100", t, {ev_done, ev_err, ev_busy, ev_wr});
            end
        end
        // 58 + 2*3 lands exactly on the result base, which is allowed.
        res_q.push_back(32'h7);
        res_q.push_back(32'h8);
        res_q.push_back(32'h9);
        done_dly = 1;
        launch(7'd58, 6'd3);
        step();
        vec++;
        if ({ev_err, ev_busy} !== 2'b01) begin
            miss++;
            $display("FAIL range_clear: err/busy %b required 01", {ev_err, ev_busy});
        end
        for (int c = 0; c < 60 && !fin; c++) begin
            step();
            if (ev_done) fin = 1'b1;
        end
        vec++;
        if (!fin || ev_err !== 1'b0 || ram[66] !== 32'h9) begin
            miss++;
            $display("FAIL range_boundary: done %0d err %b mem66 %h required 1 0 9", fin, ev_err, ram[66]);
        end
    endtask

    task automatic test_timeout();
        int wait_n = 0, wr_n = 0;
        bit fin = 1'b0, issued = 1'b0;
        init_ram();
        done_dly = 0;
        launch(7'd0, 6'd2);
        for (int c = 0; c < 400 && !fin; c++) begin
            step();
            if (issued) wait_n++;
            if (ev_hs) issued = 1'b1;
            if (ev_wr) wr_n++;
            if (ev_done) fin = 1'b1;
        end
        vec++;
        if (!fin || wait_n != 256 || ev_err !== 1'b1) begin
            miss++;
            $display("FAIL timeout_abort: done %0d cycles %0d err %b required 1 256 1", fin, wait_n, ev_err);
        end
        step();
        vec++;
        if (wr_n != 0 || ram[64] !== init_val(64) || {ev_done, ev_busy, ev_err} !== 3'b001) begin
            miss++;
            $display("FAIL timeout_nowrite: writes %0d mem64 %h done/busy/err %b required 0 %h 001", wr_n, ram[64], {ev_done, ev_busy, ev_err}, init_val(64));
        end
        done_dly = 1;
    endtask

    task automatic test_reset_midrun();
        int hs_n = 0, done_n = 0;
        bit fin = 1'b0;
        init_ram();
        queue_job(30, 3, 32'h71);
        done_dly = 4;
        launch(7'd30, 6'd3);
        for (int c = 0; c < 80 && hs_n < 2; c++) begin
            step();
            if (ev_valid && ev_hs) begin
                hs_n++;
                vec++;
                if (op_q.size() == 0 || {ev_opa, ev_opb} !== op_q[0]) begin
                    miss++;
                    $display("FAIL midrun_ops: got %h_%h", ev_opa, ev_opb);
                end
                if (op_q.size() != 0) op_q.delete(0);
            end
            if (ev_done) done_n++;
        end
        step();  // first WAIT_RES cycle of pair 2
        mr_reset_n = 1'b0;
        done_arm   = 1'b0;
        #1;
        vec++;
        if (hs_n != 2 || w_outs !== 108'h0) begin
            miss++;
            $display("FAIL midrun_reset: hs %0d outputs %h required 2 and 0", hs_n, w_outs);
        end
        repeat (3) begin
            step();
            if (ev_done) done_n++;
        end
        mr_reset_n = 1'b1;
        step();
        if (ev_done) done_n++;
        vec++;
        if (done_n != 0 || ram[64] !== 32'h71 || ram[65] !== init_val(65)) begin
            miss++;
            $display("FAIL midrun_mem: dones %0d mem64 %h mem65 %h required 0 71 %h", done_n, ram[64], ram[65], init_val(65));
        end
        // Fresh job after the reset must run cleanly.
        init_ram();
        queue_job(40, 2, 32'h55);
        done_dly = 1;
        launch(7'd40, 6'd2);
        for (int c = 0; c < 60 && !fin; c++) begin
            step();
            if (ev_valid) begin
                vec++;
                if (op_q.size() == 0 || {ev_opa, ev_opb} !== op_q[0]) begin
                    miss++;
                    $display("FAIL fresh_ops: got %h_%h", ev_opa, ev_opb);
                end
                if (ev_hs && op_q.size() != 0) op_q.delete(0);
            end
            if (ev_wr) begin
                vec++;
                if (wr_q.size() == 0 || {ev_addr, ev_wdata} !== wr_q[0]) begin
                    miss++;
                    $display("FAIL fresh_write: got addr %0d data %h", ev_addr, ev_wdata);
                end
                if (wr_q.size() != 0) wr_q.delete(0);
            end
            if (ev_done) fin = 1'b1;
        end
        vec++;
        if (!fin || ev_err !== 1'b0 || wr_q.size() != 0 || op_q.size() != 0) begin
            miss++;
            $display("FAIL fresh_end: done %0d err %b pending wr %0d op %0d required 1 0 0 0", fin, ev_err, wr_q.size(), op_q.size());
        end
    endtask

    initial begin
        mr_reset_n    = 1'b0;
        mr_start      = 1'b0;
        mr_src_base   = '0;
        mr_pair_cnt   = '0;
        mr_fpu_ready  = 1'b1;
        mr_fpu_done   = 1'b0;
        mr_fpu_result = '0;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_range_err();
        test_timeout();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "bench did not complete");
    end

endmodule
`default_nettype wire
